// File: rtl/ahb_sram_responder.sv
// rtl/ahb_sram_responder.sv - AHB-Lite SRAM slave with byte lanes, wait states and ERROR response
module ahb_sram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_write;
    logic [3:0]            r_mask;
    logic [31:0]           r_hrdata;
    logic [31:0]           r_mem [0:(2**ADDR_WIDTH)-1];

    logic                  w_ready_out;
    logic                  w_accept;
    logic                  w_illegal;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_acc_idx;
    logic [3:0]            w_acc_mask;
    logic [31:0]           w_mem_word;
    logic [31:0]           w_fwd_word;
    logic                  w_unused_bits;

    assign w_ready_out   = (r_state != S_WAIT) && (r_state != S_ERR1);
    assign w_accept      = HSEL && HREADY && HTRANS[1] && w_ready_out;
    assign w_acc_idx     = HADDR[ADDR_WIDTH+1:2];
    assign w_commit      = (r_state == S_DATA) && r_write;
    assign w_mem_word    = r_mem[w_acc_idx];
    assign w_unused_bits = ^{HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

    assign HREADYOUT = w_ready_out;
    assign HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
    assign HRDATA    = r_hrdata;

    always_comb begin
        w_illegal  = 1'b0;
        w_acc_mask = 4'b0000;
        case (HSIZE)
            3'd0: w_acc_mask = 4'b0001 << HADDR[1:0];
            3'd1: begin
                w_acc_mask = HADDR[1] ? 4'b1100 : 4'b0011;
                w_illegal  = HADDR[0];
            end
            3'd2: begin
                w_acc_mask = 4'b1111;
                w_illegal  = (HADDR[1:0] != 2'b00);
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // A read of the word being committed this edge sees the new lanes from HWDATA.
    always_comb begin
        w_fwd_word = w_mem_word;
        for (int b = 0; b < 4; b++) begin
            if (w_commit && (r_idx == w_acc_idx) && r_mask[b]) begin
                w_fwd_word[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_ERR1: w_state_nxt = S_ERR2;
            default: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        w_state_nxt = S_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = 4'(WAIT_STATES);
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_idx    <= '0;
            r_write  <= 1'b0;
            r_mask   <= 4'b0000;
            r_hrdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx   <= w_acc_idx;
                r_write <= HWRITE && !w_illegal;
                r_mask  <= w_acc_mask;
                if (!HWRITE && !w_illegal) begin
                    r_hrdata <= w_fwd_word;
                end
            end
        end
    end

    // Memory array carries no reset; a reset edge suppresses any pending commit.
    always_ff @(posedge HCLK) begin
        if (!HRESET && w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (r_mask[b]) begin
                    r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_responder.sv
// tb/tb_ahb_sram_responder.sv - directed bench for ahb_sram_responder at 0, 3 and 2 wait states
module tb_ahb_sram_responder;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [2:0]  hsel;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    wire  [2:0]  rdy;
    wire  [2:0]  resp;
    wire  [31:0] rd [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 HCLK = ~HCLK;

    ahb_sram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HREADY(rdy[0]), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADYOUT(rdy[0]), .HRDATA(rd[0]), .HRESP(resp[0]));

    ahb_sram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HREADY(rdy[1]), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADYOUT(rdy[1]), .HRDATA(rd[1]), .HRESP(resp[1]));

    ahb_sram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_ws2 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[2]), .HREADY(rdy[2]), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADYOUT(rdy[2]), .HRDATA(rd[2]), .HRESP(resp[2]));

    task automatic idle_bus();
        hsel   = 3'b000;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'd2;
        HADDR  = 32'd0;
    endtask

    task automatic addr_phase(input int k, input logic [31:0] addr, input logic wr, input logic [2:0] size);
        hsel    = 3'b000;
        hsel[k] = 1'b1;
        HADDR   = addr;
        HTRANS  = 2'b10;
        HWRITE  = wr;
        HSIZE   = size;
    endtask

    task automatic wait_ready(input int k, output int waits);
        waits = 0;
        forever begin
            @(negedge HCLK);
            if (rdy[k]) break;
            waits++;
            if (waits > 40) begin
                waits = -1;
                break;
            end
        end
    endtask

    task automatic do_write(input int k, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] data, output int waits);
        @(posedge HCLK); #1;
        addr_phase(k, addr, 1'b1, size);
        @(posedge HCLK); #1;
        idle_bus();
        HWDATA = data;
        wait_ready(k, waits);
    endtask

    task automatic do_read(input int k, input logic [31:0] addr, input logic [2:0] size,
                           output logic [31:0] data, output int waits);
        @(posedge HCLK); #1;
        addr_phase(k, addr, 1'b0, size);
        @(posedge HCLK); #1;
        idle_bus();
        wait_ready(k, waits);
        data = rd[k];
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        idle_bus();
        HWDATA = 32'd0;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (rdy[k] !== 1'b1) begin n_bad++; $display("FAIL reset_hreadyout[%0d]: got %b expected 1", k, rdy[k]); end
            n_cmp++; if (resp[k] !== 1'b0) begin n_bad++; $display("FAIL reset_hresp[%0d]: got %b expected 0", k, resp[k]); end
            n_cmp++; if (rd[k] !== 32'd0) begin n_bad++; $display("FAIL reset_hrdata[%0d]: got %h expected 00000000", k, rd[k]); end
        end
    endtask

    task automatic test_word_rw();
        int w;
        logic [31:0] d;
        do_write(0, 32'h10, 3'd2, 32'hDEADBEEF, w);
        n_cmp++; if (w !== 0) begin n_bad++; $display("FAIL word_wr_waits: got %0d expected 0", w); end
        do_read(0, 32'h10, 3'd2, d, w);
        n_cmp++; if (w !== 0) begin n_bad++; $display("FAIL word_rd_waits: got %0d expected 0", w); end
        n_cmp++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_rd_data: got %h expected deadbeef", d); end
        n_cmp++; if (resp[0] !== 1'b0) begin n_bad++; $display("FAIL word_rd_hresp: got %b expected 0", resp[0]); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] addr [5] = '{32'h10, 32'h13, 32'h10, 32'h11, 32'h12};
        logic [2:0]  size [5] = '{3'd2, 3'd0, 3'd1, 3'd0, 3'd1};
        logic [31:0] wdat [5] = '{32'h11223344, 32'h55A5A5A5, 32'h7777AAAA, 32'h12349912, 32'hBEEF0F0F};
        logic [31:0] expv [5] = '{32'h11223344, 32'h55223344, 32'h5522AAAA, 32'h552299AA, 32'hBEEF99AA};
        int w;
        logic [31:0] d;
        for (int i = 0; i < 5; i++) begin
            do_write(0, addr[i], size[i], wdat[i], w);
            do_read(0, 32'h10, 3'd2, d, w);
            n_cmp++; if (d !== expv[i]) begin n_bad++; $display("FAIL lane_step%0d: got %h expected %h", i, d, expv[i]); end
        end
        do_read(0, 32'h13, 3'd0, d, w);
        n_cmp++; if (d !== 32'hBEEF99AA) begin n_bad++; $display("FAIL byte_read_full_word: got %h expected beef99aa", d); end
    endtask

    task automatic test_back_to_back();
        int w;
        logic [31:0] d;
        do_write(0, 32'h20, 3'd2, 32'hCAFEF00D, w);
        @(posedge HCLK); #1;
        addr_phase(0, 32'h20, 1'b1, 3'd2);
        @(posedge HCLK); #1;
        HWDATA = 32'h12345678;
        addr_phase(0, 32'h20, 1'b0, 3'd2);
        @(negedge HCLK);
        n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_wr_ready: got %b expected 1", rdy[0]); end
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_rd_ready: got %b expected 1", rdy[0]); end
        n_cmp++; if (rd[0] !== 32'h12345678) begin n_bad++; $display("FAIL b2b_fwd_word: got %h expected 12345678", rd[0]); end
        @(posedge HCLK); #1;
        addr_phase(0, 32'h21, 1'b1, 3'd0);
        @(posedge HCLK); #1;
        HWDATA = 32'hC3C3EEC3;
        addr_phase(0, 32'h20, 1'b0, 3'd2);
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        n_cmp++; if (rd[0] !== 32'h1234EE78) begin n_bad++; $display("FAIL b2b_fwd_byte: got %h expected 1234ee78", rd[0]); end
        @(posedge HCLK); #1;
        addr_phase(0, 32'h24, 1'b1, 3'd2);
        @(posedge HCLK); #1;
        HWDATA = 32'h0F0F0F0F;
        addr_phase(0, 32'h20, 1'b0, 3'd2);
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        n_cmp++; if (rd[0] !== 32'h1234EE78) begin n_bad++; $display("FAIL b2b_other_word: got %h expected 1234ee78", rd[0]); end
        do_read(0, 32'h24, 3'd2, d, w);
        n_cmp++; if (d !== 32'h0F0F0F0F) begin n_bad++; $display("FAIL b2b_second_commit: got %h expected 0f0f0f0f", d); end
    endtask

    task automatic test_wait_states();
        int w;
        logic [31:0] d;
        do_write(1, 32'h0, 3'd2, 32'hA5A55A5A, w);
        n_cmp++; if (w !== 3) begin n_bad++; $display("FAIL ws3_wr_waits: got %0d expected 3", w); end
        do_read(1, 32'h0, 3'd2, d, w);
        n_cmp++; if (w !== 3) begin n_bad++; $display("FAIL ws3_rd_waits: got %0d expected 3", w); end
        n_cmp++; if (d !== 32'hA5A55A5A) begin n_bad++; $display("FAIL ws3_rd_data: got %h expected a5a55a5a", d); end
        @(posedge HCLK); #1;
        hsel[1] = 1'b1;
        HTRANS  = 2'b01;
        HADDR   = 32'h0;
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        n_cmp++; if (rdy[1] !== 1'b1) begin n_bad++; $display("FAIL ws3_busy_ready: got %b expected 1", rdy[1]); end
    endtask

    task automatic test_error();
        logic [31:0] addr [3] = '{32'h02, 32'h00, 32'h01};
        logic [2:0]  size [3] = '{3'd2, 3'd3, 3'd1};
        int w;
        logic [31:0] d;
        do_write(0, 32'h0, 3'd2, 32'h600DF00D, w);
        for (int i = 0; i < 3; i++) begin
            @(posedge HCLK); #1;
            addr_phase(0, addr[i], 1'b1, size[i]);
            HTRANS = 2'b11;
            @(posedge HCLK); #1;
            idle_bus();
            HWDATA = 32'hBADBAD00;
            @(negedge HCLK);
            n_cmp++; if ({rdy[0], resp[0]} !== 2'b01) begin n_bad++; $display("FAIL err%0d_cycle1: got rdy/resp %b expected 01", i, {rdy[0], resp[0]}); end
            @(negedge HCLK);
            n_cmp++; if ({rdy[0], resp[0]} !== 2'b11) begin n_bad++; $display("FAIL err%0d_cycle2: got rdy/resp %b expected 11", i, {rdy[0], resp[0]}); end
            @(negedge HCLK);
            n_cmp++; if ({rdy[0], resp[0]} !== 2'b10) begin n_bad++; $display("FAIL err%0d_after: got rdy/resp %b expected 10", i, {rdy[0], resp[0]}); end
            do_read(0, 32'h0, 3'd2, d, w);
            n_cmp++; if (d !== 32'h600DF00D) begin n_bad++; $display("FAIL err%0d_mem_kept: got %h expected 600df00d", i, d); end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        logic [31:0] d;
        do_write(2, 32'h40, 3'd2, 32'h13579BDF, w);
        n_cmp++; if (w !== 2) begin n_bad++; $display("FAIL ws2_wr_waits: got %0d expected 2", w); end
        do_read(2, 32'h40, 3'd2, d, w);
        n_cmp++; if (d !== 32'h13579BDF) begin n_bad++; $display("FAIL ws2_rd_data: got %h expected 13579bdf", d); end
        @(posedge HCLK); #1;
        addr_phase(2, 32'h40, 1'b1, 3'd2);
        @(posedge HCLK); #1;
        idle_bus();
        HWDATA = 32'hFFFFFFFF;
        HRESET = 1'b1;
        @(negedge HCLK);
        n_cmp++; if (rdy[2] !== 1'b0) begin n_bad++; $display("FAIL rstmid_in_wait: got %b expected 0", rdy[2]); end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        n_cmp++; if (rdy[2] !== 1'b1) begin n_bad++; $display("FAIL rstmid_hreadyout: got %b expected 1", rdy[2]); end
        n_cmp++; if (resp[2] !== 1'b0) begin n_bad++; $display("FAIL rstmid_hresp: got %b expected 0", resp[2]); end
        n_cmp++; if (rd[2] !== 32'd0) begin n_bad++; $display("FAIL rstmid_hrdata: got %h expected 00000000", rd[2]); end
        repeat (4) @(negedge HCLK);
        n_cmp++; if (rdy[2] !== 1'b1) begin n_bad++; $display("FAIL rstmid_stays_idle: got %b expected 1", rdy[2]); end
        do_read(2, 32'h40, 3'd2, d, w);
        n_cmp++; if (d !== 32'h13579BDF) begin n_bad++; $display("FAIL rstmid_mem_kept: got %h expected 13579bdf", d); end
        n_cmp++; if (w !== 2) begin n_bad++; $display("FAIL rstmid_rd_waits: got %0d expected 2", w); end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_sram_responder.md
Name: ahb_sram_responder

Overview:
AHB-Lite slave memory, the responder end of the AHB-Lite master bus driven by the DMA engine and the cores. It holds a word-organised on-chip SRAM and returns read data or commits write data with byte-lane masking. It inserts a programmable number of wait states. Misaligned or oversized transfers get a standard two-cycle ERROR response.

Parameters:
ADDR_WIDTH, 10, word-address bits; memory = 2^ADDR_WIDTH x 32-bit words (default 4 KB), indexed by HADDR[ADDR_WIDTH+1:2].
WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (0..15).

Ports:
HCLK  in  1  bus clock; all logic on rising edge.
HRESET  in  1  synchronous active-high reset.
HSEL  in  1  slave select from decoder.
HREADY  in  1  bus ready (previous data phase complete).
HADDR  in  32  address.
HTRANS  in  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) are transfers.
HWRITE  in  1  1 = write.
HSIZE  in  3  0 byte, 1 halfword, 2 word.
HWDATA  in  32  write data, valid in the data phase.
HREADYOUT  out  1  slave ready.
HRDATA  out  32  read data.
HRESP  out  1  0 OKAY, 1 ERROR.

Behaviour:
- Interface: one clock, HCLK; reset HRESET is synchronous, active-high.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0, pending write cleared. SRAM contents are not reset. A reset asserted mid data phase aborts the transfer and discards any uncommitted write.
- Accept: an address phase is taken at an edge where HSEL & HREADY & HTRANS[1]. On that edge latch the word index, HWRITE, HSIZE and the byte-lane mask (little-endian):
  - word: 4'b1111
  - halfword: 4'b0011 << 2*HADDR[1]
  - byte: 4'b0001 << HADDR[1:0]
- IDLE/BUSY or HSEL=0 produces a zero-wait OKAY data phase.
- Error check at accept: HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0 -> ERR1.
- States:
  - IDLE: HREADYOUT=1, HRESP=0. On an accepted legal transfer go to DATA if WAIT_STATES=0, else load counter=WAIT_STATES and go to WAIT. Illegal transfer -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; at 1 go to DATA.
  - DATA: HREADYOUT=1, HRESP=0; final data-phase cycle. A new address phase may be accepted on this same edge (back-to-back pipelining), following the IDLE transition rules; otherwise return to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; may accept a new address phase as in DATA, else -> IDLE.
- Write: HWDATA is sampled on the edge that ends the data phase (HREADYOUT=1 cycle). Only masked lanes of the addressed word are written. An errored transfer never writes.
- Read, WAIT_STATES=0: HRDATA is registered from SRAM on the accept edge, so it is valid in the single DATA cycle.
- Read, WAIT_STATES>0: HRDATA is loaded no later than the edge entering DATA.
- Read-after-write hazard: a read accepted on the same edge that commits a write to the same word returns the merged word. Written lanes come from HWDATA; the remaining lanes come from SRAM.
- HRDATA holds its last value outside read data phases. Unused byte lanes of byte/halfword reads return the full stored word.
- HRESP=1 is never combined with HREADYOUT=1 in a cycle other than ERR2.

Test Plan:
- WAIT_STATES=0: word write 0xDEADBEEF @0x10, then word read @0x10 -> each data phase 1 cycle, HREADYOUT always 1, HRDATA=0xDEADBEEF.
- Byte write 0x55 @0x13 over 0x11223344 in word 4, then read word 4 -> 0x55223344; halfword write 0xAAAA @0x10 -> 0x5522AAAA.
- Back-to-back word write 0x12345678 @0x20 with read @0x20 accepted on the write's data edge -> read returns 0x12345678 (forwarding), no extra cycle.
- WAIT_STATES=3: read @0x0 -> HREADYOUT low exactly 3 cycles, then high with correct data; the master's next address is held until then.
- Word access @0x02 -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1, memory at word 0 unchanged; HSIZE=3 -> same ERROR response.
- HRESET pulsed during WAIT of a write (WAIT_STATES=2) -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0, target word unchanged.
